mem_access_ctrl: RTL and testbench

- Memory-stage controller sitting directly upstream of the data RAM wrapper.
- Accepts one load/store request at a time from the execute stage and sequences the RAM port around the block RAM's synchronous read latency.
- Performs the read-then-write sequence that sub-word stores need, so the RAM wrapper's merge always sees valid old data.
- Returns load data or store acknowledge, flags misaligned or illegal accesses, and stalls the pipeline while busy.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/mem_align_chk.sv | 22 ++
 rtl/mem_access_ctrl.sv | 117 +++++++++++
 tb/tb_mem_access_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage controller: access-type encodings,
// FSM states and access-type classification helpers.
package mem_pkg;

  localparam logic [2:0] RW_B  = 3'b000;
  localparam logic [2:0] RW_H  = 3'b001;
  localparam logic [2:0] RW_W  = 3'b010;
  localparam logic [2:0] RW_BU = 3'b100;
  localparam logic [2:0] RW_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ST_W  = 3'd2,
    S_ST_RD = 3'd3,
    S_ST_WR = 3'd4,
    S_RESP  = 3'd5
  } state_e;

  function automatic logic is_half(input logic [2:0] t);
    return (t == RW_H) || (t == RW_HU);
  endfunction

  function automatic logic is_word(input logic [2:0] t);
    return t == RW_W;
  endfunction

  function automatic logic is_legal(input logic [2:0] t);
    return (t == RW_B) || (t == RW_H) || (t == RW_W) || (t == RW_BU) || (t == RW_HU);
  endfunction

endpackage

// File: rtl/mem_align_chk.sv
// Combinational access checker: flags illegal access types and accesses that
// are not naturally aligned to their size.
module mem_align_chk
  import mem_pkg::*;
(
  input  logic [1:0] addr_i,
  input  logic [2:0] type_i,
  output logic       err_o
);

  always_comb begin
    err_o = 1'b0;
    if (!is_legal(type_i)) begin
      err_o = 1'b1;
    end else if (is_half(type_i) && addr_i[0]) begin
      err_o = 1'b1;
    end else if (is_word(type_i) && (addr_i != 2'b00)) begin
      err_o = 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: one request at a time, sequences the data RAM port
// around its read latency and does read-then-write for sub-word stores.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_type,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              stall,
  output logic              ram_wr_en,
  output logic [31:0]       ram_addr,
  output logic [2:0]        ram_rw_type,
  output logic [31:0]       ram_dat_i,
  input  logic [31:0]       ram_dat_o
);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        type_q, type_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              acc_err;

  mem_align_chk u_align_chk (
    .addr_i (req_addr[1:0]),
    .type_i (req_type),
    .err_o  (acc_err)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    type_d  = type_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          type_d  = req_type;
          wdata_d = req_wdata;
          cnt_d   = 2'd0;
          rdata_d = 32'd0;
          err_d   = acc_err;
          if (acc_err)               state_d = S_RESP;
          else if (!req_we)          state_d = S_LOAD;
          else if (is_word(req_type)) state_d = S_ST_W;
          else                       state_d = S_ST_RD;
        end
      end
      // One cycle to present the address plus RD_LAT cycles until douta is valid.
      S_LOAD: begin
        if (cnt_q == 2'(RD_LAT)) begin
          rdata_d = ram_dat_o;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_ST_W: state_d = S_RESP;
      S_ST_RD: begin
        if (cnt_q == 2'(RD_LAT - 1)) state_d = S_ST_WR;
        else                         cnt_d   = cnt_q + 2'd1;
      end
      S_ST_WR: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= '0;
      type_q  <= RW_W;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      type_q  <= type_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign stall       = !req_ready || req_valid;
  // Reset in the write cycle drops the strobe so the interrupted store never lands.
  assign ram_wr_en   = ((state_q == S_ST_W) || (state_q == S_ST_WR)) && !rst;
  assign ram_addr    = 32'(addr_q);
  assign ram_rw_type = type_q;
  assign ram_dat_i   = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with a behavioural RAM wrapper and a
// byte-level reference memory.
module tb_mem_access_ctrl;

  localparam int RD_LAT = 1;
  localparam logic [2:0] T_B = 3'b000, T_H = 3'b001, T_W = 3'b010, T_BU = 3'b100, T_HU = 3'b101;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_type;
  logic        rsp_valid, rsp_err, stall;
  logic [31:0] rsp_rdata;
  logic        ram_wr_en;
  logic [31:0] ram_addr, ram_dat_i, ram_dat_o;
  logic [2:0]  ram_rw_type;

  int checks = 0;
  int failures = 0;

  mem_access_ctrl #(.RD_LAT(RD_LAT), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_type(req_type), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .stall(stall),
    .ram_wr_en(ram_wr_en), .ram_addr(ram_addr), .ram_rw_type(ram_rw_type),
    .ram_dat_i(ram_dat_i), .ram_dat_o(ram_dat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM wrapper model: word array, lane merge on write, extension on read.
  logic [31:0] ram_w [0:63];
  logic        pre_en;
  logic [5:0]  pre_idx;
  logic [31:0] pre_val;
  logic [31:0] rd1, rd2;

  function automatic logic [31:0] wrap_rd(input logic [31:0] w, input logic [1:0] o, input logic [2:0] t);
    logic [31:0] s;
    s = w >> (8 * o);
    case (t)
      T_B:     return {{24{s[7]}}, s[7:0]};
      T_BU:    return {24'd0, s[7:0]};
      T_H:     return {{16{s[15]}}, s[15:0]};
      T_HU:    return {16'd0, s[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] wrap_wr(input logic [31:0] w, input logic [1:0] o, input logic [2:0] t,
                                          input logic [31:0] d);
    logic [31:0] m;
    m = w;
    case (t[1:0])
      2'b00:   m[8*o +: 8] = d[7:0];
      2'b01:   m[16*o[1] +: 16] = d[15:0];
      default: m = d;
    endcase
    return m;
  endfunction

  always @(posedge clk) begin
    if (pre_en) ram_w[pre_idx] <= pre_val;
    else if (ram_wr_en) ram_w[ram_addr[7:2]] <= wrap_wr(ram_w[ram_addr[7:2]], ram_addr[1:0], ram_rw_type, ram_dat_i);
    rd1 <= wrap_rd(ram_w[ram_addr[7:2]], ram_addr[1:0], ram_rw_type);
    rd2 <= rd1;
  end
  assign ram_dat_o = (RD_LAT == 2) ? rd2 : rd1;

  // Reference memory, byte addressed.
  logic [7:0] ref_b [0:255];

  function automatic logic [31:0] ref_load(input logic [7:0] a, input logic [2:0] t);
    case (t)
      T_B:     return {{24{ref_b[a][7]}}, ref_b[a]};
      T_BU:    return {24'd0, ref_b[a]};
      T_H:     return {{16{ref_b[a+8'd1][7]}}, ref_b[a+8'd1], ref_b[a]};
      T_HU:    return {16'd0, ref_b[a+8'd1], ref_b[a]};
      default: return {ref_b[a+8'd3], ref_b[a+8'd2], ref_b[a+8'd1], ref_b[a]};
    endcase
  endfunction

  task automatic preload(input logic [7:0] a, input logic [31:0] v);
    pre_en = 1'b1; pre_idx = a[7:2]; pre_val = v;
    for (int k = 0; k < 4; k++) ref_b[{a[7:2], 2'b00} + 8'(k)] = v[8*k +: 8];
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // Issue one request from IDLE and observe it until its response.
  task automatic do_req(input logic we, input logic [2:0] ty, input logic [7:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int nwr, output int wr_at);
    int guard;
    req_valid = 1'b1; req_we = we; req_type = ty; req_addr = {24'd0, a}; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; nwr = 0; wr_at = -1;
    while (!rsp_valid && lat < 20) begin
      if (ram_wr_en) begin nwr++; wr_at = lat; end
      @(posedge clk); #1; lat++;
    end
    if (ram_wr_en) nwr++;
    rd = rsp_rdata; er = rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; req_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'd0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", rsp_err); end
    checks++; if (ram_wr_en !== 1'b0) begin failures++; $display("FAIL rst_wr_en got=%b exp=0", ram_wr_en); end
    checks++; if (ram_addr !== 32'd0) begin failures++; $display("FAIL rst_addr got=%h exp=0", ram_addr); end
    checks++; if (ram_rw_type !== 3'b010) begin failures++; $display("FAIL rst_rw_type got=%b exp=010", ram_rw_type); end
    checks++; if (ram_dat_i !== 32'd0) begin failures++; $display("FAIL rst_dat_i got=%h exp=0", ram_dat_i); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall); end
    rst = 1'b0;
    @(posedge clk); #1;
    // Reset coincident with a request: the request must not be taken.
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_type = T_W; req_addr = 32'h50; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_vs_req_ready got=%b exp=1", req_ready); end
    n = 0;
    repeat (5) begin if (rsp_valid || ram_wr_en) n++; @(posedge clk); #1; end
    checks++; if (n !== 0) begin failures++; $display("FAIL rst_vs_req_activity got=%0d exp=0", n); end
  endtask

  task automatic test_load_word();
    int lat, nwr, wat; logic [31:0] rd; logic er;
    preload(8'h40, 32'h8899AABB);
    do_req(1'b0, T_W, 8'h40, 32'd0, lat, rd, er, nwr, wat);
    checks++; if (lat !== RD_LAT + 2) begin failures++; $display("FAIL lw_latency got=%0d exp=%0d", lat, RD_LAT + 2); end
    checks++; if (rd !== 32'h8899AABB) begin failures++; $display("FAIL lw_rdata got=%h exp=8899aabb", rd); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL lw_err got=%b exp=0", er); end
    checks++; if (nwr !== 0) begin failures++; $display("FAIL lw_wr_en_cycles got=%0d exp=0", nwr); end
  endtask

  task automatic test_subword_store();
    int lat, nwr, wat; logic [31:0] rd; logic er;
    preload(8'h40, 32'h11223344);
    do_req(1'b1, T_B, 8'h42, 32'h000000A5, lat, rd, er, nwr, wat);
    checks++; if (lat !== RD_LAT + 2) begin failures++; $display("FAIL sb_latency got=%0d exp=%0d", lat, RD_LAT + 2); end
    checks++; if (nwr !== 1) begin failures++; $display("FAIL sb_wr_en_cycles got=%0d exp=1", nwr); end
    checks++; if (wat !== RD_LAT + 1) begin failures++; $display("FAIL sb_wr_en_cycle got=%0d exp=%0d", wat, RD_LAT + 1); end
    checks++; if (er !== 1'b0 || rd !== 32'd0) begin failures++; $display("FAIL sb_rsp got=%b/%h exp=0/0", er, rd); end
    do_req(1'b0, T_W, 8'h40, 32'd0, lat, rd, er, nwr, wat);
    checks++; if (rd !== 32'h11A53344) begin failures++; $display("FAIL sb_readback got=%h exp=11a53344", rd); end
  endtask

  task automatic test_word_store();
    int lat, nwr, wat; logic [31:0] rd; logic er;
    do_req(1'b1, T_W, 8'h44, 32'hDEADBEEF, lat, rd, er, nwr, wat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL sw_latency got=%0d exp=2", lat); end
    checks++; if (nwr !== 1 || wat !== 1) begin failures++; $display("FAIL sw_wr_en got=%0d@%0d exp=1@1", nwr, wat); end
    do_req(1'b0, T_W, 8'h44, 32'd0, lat, rd, er, nwr, wat);
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_readback got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_errors();
    int lat, nwr, wat; logic [31:0] rd; logic er;
    do_req(1'b0, T_H, 8'h41, 32'd0, lat, rd, er, nwr, wat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL lh_mis_latency got=%0d exp=1", lat); end
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL lh_mis_rsp got=%b/%h exp=1/0", er, rd); end
    do_req(1'b1, T_W, 8'h46, 32'h55555555, lat, rd, er, nwr, wat);
    checks++; if (er !== 1'b1 || nwr !== 0) begin failures++; $display("FAIL sw_mis got=err%b/wr%0d exp=err1/wr0", er, nwr); end
    do_req(1'b0, T_W, 8'h44, 32'd0, lat, rd, er, nwr, wat);
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_mis_unchanged got=%h exp=deadbeef", rd); end
    do_req(1'b0, 3'b011, 8'h40, 32'd0, lat, rd, er, nwr, wat);
    checks++; if (er !== 1'b1 || lat !== 1) begin failures++; $display("FAIL type011 got=err%b/lat%0d exp=err1/lat1", er, lat); end
  endtask

  task automatic test_reset_in_write();
    int lat, nwr, wat, n; logic [31:0] rd; logic er;
    preload(8'h48, 32'hCAFEF00D);
    req_valid = 1'b1; req_we = 1'b1; req_type = T_H; req_addr = 32'h40; req_wdata = 32'h00001234;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    while (!ram_wr_en && n < 10) begin @(posedge clk); #1; n++; end
    checks++; if (n !== RD_LAT + 1) begin failures++; $display("FAIL sh_wr_cycle got=%0d exp=%0d", n, RD_LAT + 1); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (req_ready !== 1'b1 || ram_wr_en !== 1'b0) begin failures++; $display("FAIL rst_wr_state got=rdy%b/we%b exp=rdy1/we0", req_ready, ram_wr_en); end
    n = 0;
    repeat (4) begin if (rsp_valid) n++; @(posedge clk); #1; end
    checks++; if (n !== 0) begin failures++; $display("FAIL rst_wr_rsp got=%0d exp=0", n); end
    do_req(1'b0, T_W, 8'h48, 32'd0, lat, rd, er, nwr, wat);
    checks++; if (rd !== 32'hCAFEF00D || lat !== RD_LAT + 2) begin failures++; $display("FAIL post_rst_lw got=%h/lat%0d exp=cafef00d/lat%0d", rd, lat, RD_LAT + 2); end
  endtask

  task automatic test_back_to_back();
    int c, gap; logic [31:0] rd1_s;
    preload(8'h40, 32'h80112233);
    req_valid = 1'b1; req_we = 1'b0; req_type = T_B; req_addr = 32'h43; req_wdata = 32'd0;
    @(posedge clk); #1;
    req_type = T_BU;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL b2b_stall got=%b exp=1", stall); end
    c = 0;
    while (!rsp_valid && c < 20) begin @(posedge clk); #1; c++; end
    rd1_s = rsp_rdata;
    checks++; if (rd1_s !== ref_load(8'h43, T_B)) begin failures++; $display("FAIL b2b_lb got=%h exp=%h", rd1_s, ref_load(8'h43, T_B)); end
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_after_rsp got=%b exp=1", req_ready); end
    gap = 1;
    while (!rsp_valid && gap < 20) begin @(posedge clk); #1; gap++; end
    req_valid = 1'b0;
    checks++; if (gap !== RD_LAT + 3) begin failures++; $display("FAIL b2b_gap got=%0d exp=%0d", gap, RD_LAT + 3); end
    checks++; if (rsp_rdata !== 32'h00000080) begin failures++; $display("FAIL b2b_lbu got=%h exp=00000080", rsp_rdata); end
    checks++; if (ram_rw_type !== T_BU) begin failures++; $display("FAIL b2b_rw_type got=%b exp=100", ram_rw_type); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) preload(8'h40 + 8'(4 * i), $urandom);
    for (int i = 0; i < 60; i++) begin
      logic [7:0] a; logic [2:0] t; logic we; logic [31:0] wd, rd, exp_rd; logic er, exp_err;
      int lat, nwr, wat, exp_lat;
      a = 8'h40 + 8'($urandom_range(0, 31));
      t = 3'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      exp_err = (t == 3'b011) || (t == 3'b110) || (t == 3'b111) ||
                (((t == T_H) || (t == T_HU)) && a[0]) || ((t == T_W) && (a[1:0] != 2'b00));
      exp_rd = (!exp_err && !we) ? ref_load(a, t) : 32'd0;
      if (exp_err) exp_lat = 1;
      else if (we && t == T_W) exp_lat = 2;
      else exp_lat = RD_LAT + 2;
      do_req(we, t, a, wd, lat, rd, er, nwr, wat);
      if (we && !exp_err) begin
        ref_b[a] = wd[7:0];
        if (t[1:0] != 2'b00) ref_b[a + 8'd1] = wd[15:8];
        if (t == T_W) begin ref_b[a + 8'd2] = wd[23:16]; ref_b[a + 8'd3] = wd[31:24]; end
      end
      checks++; if (er !== exp_err) begin failures++; $display("FAIL rnd%0d_err got=%b exp=%b", i, er, exp_err); end
      checks++; if (lat !== exp_lat) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, exp_lat); end
      checks++; if (rd !== exp_rd) begin failures++; $display("FAIL rnd%0d_rdata got=%h exp=%h", i, rd, exp_rd); end
      checks++; if (nwr !== ((we && !exp_err) ? 1 : 0)) begin failures++; $display("FAIL rnd%0d_wr_cycles got=%0d exp=%0d", i, nwr, (we && !exp_err) ? 1 : 0); end
      if (we && !exp_err) begin
        checks++; if (wat !== ((t == T_W) ? 1 : RD_LAT + 1)) begin failures++; $display("FAIL rnd%0d_wr_cycle got=%0d exp=%0d", i, wat, (t == T_W) ? 1 : RD_LAT + 1); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_type = T_W; req_wdata = 32'd0;
    pre_en = 1'b0; pre_idx = 6'd0; pre_val = 32'd0;
    test_reset();
    test_load_word();
    test_subword_store();
    test_word_store();
    test_errors();
    test_reset_in_write();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
